// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with glitch filter, frame checking, timeout, scancode FIFO and interrupt
//   CLK      system clock
//   RST      asynchronous active-low reset
//   KB_CLK   PS/2 clock pin (asynchronous)
//   KB_DATA  PS/2 data pin (asynchronous)
//   SEL      chip select, active high
//   A0       register select: 0 = DATA, 1 = STATUS
//   R, W     read / write strobes, active low
//   DIN      CPU write data
//   DOUT     CPU read data (FIFO head or STATUS)
//   DOE      DOUT enable, SEL & ~R
//   INT      registered interrupt, IEN & NE
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2048
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    input  logic       SEL,
    input  logic       A0,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       INT
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          kc_m, kc_s, kd_m, kd_s;
    logic          filt, flip, fall;
    logic [FW-1:0] fcnt;
    state_t        state, state_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt;
    logic          tmo, push, set_perr, set_ferr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          ne, full, rd_now, rd_q, pop, flush, swr, do_push, set_ovr;
    logic          ien, ovr, perr, ferr;
    logic          unused_din;

    assign unused_din = ^{DIN[7:6], DIN[1:0]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            {kc_m, kc_s, kd_m, kd_s} <= 4'hF;
        end else begin
            kc_m <= KB_CLK;
            kc_s <= kc_m;
            kd_m <= KB_DATA;
            kd_s <= kd_m;
        end
    end

    // filtered clock follows the synchronised pin only after FILTER_LEN differing samples in a row
    assign flip = (kc_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
    assign fall = flip && filt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (kc_s == filt || flip) begin
            filt <= kc_s;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign tmo = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            bcnt  <= '0;
            sh    <= '0;
            par   <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            sh    <= sh_n;
            par   <= par_n;
            tcnt  <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        sh_n     = sh;
        par_n    = par;
        push     = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        if (tmo) begin
            state_n  = IDLE;
            bcnt_n   = '0;
            set_ferr = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n = kd_s ? IDLE : DATA;
                    bcnt_n  = '0;
                end
                DATA: begin
                    sh_n    = {kd_s, sh[7:1]};
                    bcnt_n  = bcnt + 3'd1;
                    state_n = (bcnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = kd_s;
                    state_n = STOP;
                end
                default: begin
                    state_n  = IDLE;
                    set_ferr = !kd_s;
                    set_perr = !(^sh ^ par);
                    push     = kd_s && (^sh ^ par);
                end
            endcase
        end
    end

    assign ne      = (cnt != '0);
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign rd_now  = SEL && !A0 && !R;
    // pop on the trailing edge of the read strobe so a long strobe pops once
    assign pop     = rd_q && !rd_now && ne;
    assign flush   = SEL && !W && !A0;
    assign swr     = SEL && !W && A0;
    assign do_push = push && (!full || pop) && !flush;
    assign set_ovr = push && full && !pop && !flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_q <= 1'b0;
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
        end else begin
            rd_q <= rd_now;
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= do_push ? wp + 1'b1 : wp;
                rp  <= pop ? rp + 1'b1 : rp;
                cnt <= cnt + CW'(do_push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wp] <= sh;
    end

    // a clear and a set in the same cycle leave the flag set
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ien  <= 1'b0;
            ovr  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            INT  <= 1'b0;
        end else begin
            ien  <= swr ? DIN[5] : ien;
            ovr  <= (ovr && !(swr && DIN[2])) || set_ovr;
            perr <= (perr && !(swr && DIN[3])) || set_perr;
            ferr <= (ferr && !(swr && DIN[4])) || set_ferr;
            INT  <= ien && ne;
        end
    end

    assign DOE  = SEL && !R;
    assign DOUT = A0 ? {2'b00, ien, ferr, perr, ovr, full, ne} : (ne ? mem[rp] : 8'h00);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized and directed checks of ps2_rx_fifo against a queue-based reference model
module tb_ps2_rx_fifo;
    localparam int H     = 12;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kb_clk = 1'b1, kb_data = 1'b1;
    logic       sel = 1'b0, a0 = 1'b0, r = 1'b1, w = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       doe, irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic       ien = 1'b0, ovr = 1'b0, perr = 1'b0, ferr = 1'b0;

    ps2_rx_fifo dut (
        .CLK(clk), .RST(rst_n), .KB_CLK(kb_clk), .KB_DATA(kb_data),
        .SEL(sel), .A0(a0), .R(r), .W(w), .DIN(din),
        .DOUT(dout), .DOE(doe), .INT(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {2'b00, ien, ferr, perr, ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        @(negedge clk);
        sel = 1'b1; a0 = a; r = 1'b0;
        @(negedge clk);
        v = dout;
        sel = 1'b0; r = 1'b1;
        cyc(2);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; a0 = a; w = 1'b0; din = d;
        @(negedge clk);
        sel = 1'b0; w = 1'b1;
        cyc(1);
    endtask

    task automatic read_data(input string tag);
        logic [7:0] v, e;
        rd(1'b0, v);
        e = (q.size() != 0) ? q.pop_front() : 8'h00;
        chk(tag, v, e);
    endtask

    task automatic read_status(input string tag);
        logic [7:0] v;
        rd(1'b1, v);
        chk(tag, v, exp_status());
    endtask

    task automatic write_status(input logic [7:0] d);
        wr(1'b1, d);
        ien = d[5];
        if (d[2]) ovr = 1'b0;
        if (d[3]) perr = 1'b0;
        if (d[4]) ferr = 1'b0;
    endtask

    task automatic ps2_bit(input logic b);
        kb_data = b;
        cyc(H);
        kb_clk = 1'b0;
        cyc(H);
        kb_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ bad_par);
        ps2_bit(~bad_stop);
        kb_data = 1'b1;
        cyc(20);
        if (bad_stop) ferr = 1'b1;
        if (bad_par) perr = 1'b1;
        if (!bad_stop && !bad_par) begin
            if (q.size() == DEPTH) ovr = 1'b1;
            else q.push_back(d);
        end
    endtask

    initial begin
        logic [7:0] v;
        int ne_c, int_c, op;
        cyc(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_doe", doe, 1'b0);
        chk("rst_int", irq, 1'b0);
        rst_n = 1'b1;
        cyc(2);
        read_status("rst_status");

        send(8'h1C, 1'b0, 1'b0);
        read_status("t1_status");
        read_data("t1_data");
        read_status("t1_status_empty");

        write_status(8'h20);
        @(negedge clk);
        sel = 1'b1; a0 = 1'b1; r = 1'b0;
        ne_c = -1;
        int_c = -1;
        fork
            send(8'hF0, 1'b0, 1'b0);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (dout[0] && ne_c < 0) ne_c = i;
                if (irq && int_c < 0) int_c = i;
            end
        join
        sel = 1'b0; r = 1'b1;
        chk("int_after_ne", int_c - ne_c, 1);
        chk("ne_seen", ne_c >= 0, 1);
        @(negedge clk);
        sel = 1'b1; a0 = 1'b0; r = 1'b0;
        cyc(2);
        chk("t2_data", dout, q[0]);
        chk("t2_doe", doe, 1'b1);
        sel = 1'b0; r = 1'b1;
        void'(q.pop_front());
        @(negedge clk);
        chk("t2_int_hold", irq, 1'b1);
        chk("t2_doe_off", doe, 1'b0);
        @(negedge clk);
        chk("t2_int_fall", irq, 1'b0);

        send(8'h1C, 1'b1, 1'b0);
        read_status("t3_perr");
        write_status(8'h08);
        read_status("t3_clear");

        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0);
        read_status("t4_full_ovr");
        for (int i = 0; i < 9; i++) read_data("t4_data");
        write_status(8'h04);
        read_status("t4_clear");

        @(negedge clk);
        kb_clk = 1'b0;
        cyc(2);
        kb_clk = 1'b1;
        cyc(10);
        read_status("t5_glitch");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        kb_data = 1'b1;
        cyc(1800);
        read_status("t5_before_tmo");
        cyc(400);
        ferr = 1'b1;
        read_status("t5_tmo_ferr");
        send(8'h5A, 1'b0, 1'b0);
        read_data("t5_data");
        write_status(8'h10);

        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        write_status(8'h20);
        chk("t6_int_pre", irq, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        kb_data = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        q.delete();
        {ien, ovr, perr, ferr} = 4'b0000;
        cyc(2);
        read_status("t6_status");
        chk("t6_int", irq, 1'b0);
        send(8'h29, 1'b0, 1'b0);
        read_data("t6_data");

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            else if (op <= 6) read_data("rnd_data");
            else if (op == 7) read_status("rnd_status");
            else if (op == 8) write_status(8'($urandom) & 8'h3C);
            else if ($urandom_range(0, 2) == 0) begin
                wr(1'b0, 8'h00);
                q.delete();
            end else read_status("rnd_status2");
            chk("rnd_int", irq, ien && q.size() != 0);
        end
        read_status("final_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver for the Flounder CPLD. It sits in the CPLD I/O window as the next generation of the single-byte scancode latch. It adds a synchroniser and glitch filter on the PS/2 lines, start/parity/stop checking, a mid-frame timeout, a scancode FIFO, sticky error flags and a level interrupt. The top level decodes the chip select and drives the tristate data bus from DOUT/DOE.

## Interface
Parameters:
- FIFO_DEPTH, 8, scancode FIFO entries; power of two, 2..32
- FILTER_LEN, 4, consecutive equal samples needed before the filtered KB_CLK changes; 2..15
- TIMEOUT, 2048, CLK cycles without a filtered KB_CLK fall before an open frame is aborted

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- KB_CLK  in  1  PS/2 clock pin, asynchronous
- KB_DATA  in  1  PS/2 data pin, asynchronous
- SEL  in  1  chip select from top-level decode, active high
- A0  in  1  register select: 0 = DATA, 1 = STATUS
- R  in  1  read strobe, active low
- W  in  1  write strobe, active low
- DIN  in  8  CPU write data
- DOUT  out  8  CPU read data
- DOE  out  1  DOUT enable: SEL & ~R, combinational
- INT  out  1  interrupt, active high

## Operation
- KB_CLK and KB_DATA each pass through a 2-FF synchroniser.
- Filtered clock: reset value 1. It takes the synchronised value once that value has held for FILTER_LEN consecutive cycles.
- Every falling edge of the filtered clock samples the synchronised KB_DATA.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sample 0 -> DATA, bit counter = 0. Sample 1 is ignored.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: check the frame, then -> IDLE.
- Frame is good when: stop bit = 1, and XOR(data[7:0], parity) = 1 (odd parity).
  - Stop bit = 0: set FERR, drop the byte.
  - Parity bad: set PERR, drop the byte.
  - Both bad: set both flags.
- Timeout: in any state other than IDLE, count cycles since the last filtered fall. When the count reaches TIMEOUT: set FERR, go to IDLE, clear the bit counter.
- Good byte: push into the FIFO.
  - FIFO full with no pop in the same cycle: set OVR, drop the byte. FIFO contents unchanged.
- DATA read: DOUT = FIFO head, or 0x00 when empty.
  - Pop happens on the cycle after the qualified read SEL & ~A0 & ~R deasserts. A multi-cycle strobe therefore pops exactly once.
  - Pop when empty is a no-op.
- STATUS read: bit0 NE (not empty), bit1 FULL, bit2 OVR, bit3 PERR, bit4 FERR, bit5 IEN, bits 7:6 = 0.
- Writes act in any cycle where SEL & ~W is true and are idempotent, so multi-cycle strobes are safe.
  - STATUS write: IEN <= DIN[5]; DIN[2], DIN[3], DIN[4] written as 1 clear OVR, PERR, FERR respectively.
  - DATA write: flush the FIFO (pointers and count to 0). The frame FSM is unaffected.
- INT = IEN & NE, registered.

## Timing
- Reset values: DOUT = 0x00, DOE = 0 (DOE is combinational, so this holds while strobes are idle), INT = 0, IEN = 0, all flags 0, FIFO empty, FSM IDLE, filtered clock 1, synchronisers 1.
- Asynchronous reset mid-frame discards the partial frame and the FIFO contents.
- Pin-to-push latency: push occurs 2 + FILTER_LEN cycles after the pin edge of the stop-bit fall (+1 cycle for pin asynchrony). NE is visible in the next cycle; INT one cycle after NE.
- Glitch rejection: a pulse shorter than FILTER_LEN cycles on either line produces no edge.
- Push and pop in the same cycle: both take effect and the count is unchanged. This also holds when the FIFO is full, so no OVR is set.
- Flush and push in the same cycle: flush wins, the byte is lost, no flag is set.
- Flag clear and flag set in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. FULL when count = FIFO_DEPTH.

## Test plan
- Send 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1). Expected: STATUS = 0x01. DATA read returns 0x1C, then STATUS = 0x00.
- Write STATUS 0x20, then send 0xF0 (parity 1). Expected: INT rises 1 cycle after NE. Read DATA returns 0xF0; INT falls 2 cycles after strobe release.
- Send 0x1C with parity 1. Expected: STATUS = 0x08, FIFO empty. Write STATUS 0x08 -> STATUS = 0x00.
- FIFO_DEPTH = 8: send 0x01..0x09. Expected: STATUS = 0x07. Eight reads return 0x01..0x08, a ninth returns 0x00.
- FILTER_LEN = 4: inject a 2-cycle low glitch on KB_CLK in IDLE. Expected: no state change. Then 5 bits only and go idle. Expected: FERR set after TIMEOUT cycles. A following 0x5A frame is received correctly.
- Assert RST mid-frame with two bytes queued. Expected: STATUS = 0x00, INT = 0. The next full 0x29 frame is received.
